// File: rtl/breathe_pkg.sv
// rtl/breathe_pkg.sv - shared types and helpers for the breathe envelope sequencer
package breathe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_HOLD_HI   = 3'd2,
        ST_RAMP_DOWN = 3'd3,
        ST_HOLD_LO   = 3'd4
    } state_t;

    localparam int DEF_DUTY_W   = 7;
    localparam int DEF_DUTY_MAX = (1 << DEF_DUTY_W) - 1;

    function automatic int duty_max(input int duty_w);
        return (1 << duty_w) - 1;
    endfunction

    function automatic int presc_div(input int base_div, input logic [1:0] speed);
        return base_div << speed;
    endfunction

endpackage

// File: rtl/step_prescaler.sv
// rtl/step_prescaler.sv - envelope step-rate prescaler with speed latched at each step wrap
module step_prescaler
    import breathe_pkg::*;
#(
    parameter int BASE_DIV = 4096,
    parameter int PRESC_W  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic [1:0] speed,
    output logic       step_tick
);

    logic [PRESC_W-1:0] count;
    logic [PRESC_W-1:0] last;
    logic [1:0]         speed_q;

    // Speed only takes effect from the next step, so the running count never jumps.
    always_comb begin
        last = PRESC_W'(presc_div(BASE_DIV, speed_q) - 1);
    end

    assign step_tick = !clear && (count == last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count   <= '0;
            speed_q <= '0;
        end else if (clear || step_tick) begin
            count   <= '0;
            speed_q <= speed;
        end else begin
            count   <= count + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/breathe_seq.sv
// rtl/breathe_seq.sv - LED breathe envelope FSM with PWM-wrap-aligned duty shadow register
module breathe_seq
    import breathe_pkg::*;
#(
    parameter int DUTY_W     = DEF_DUTY_W,
    parameter int BASE_DIV   = 4096,
    parameter int PRESC_W    = 16,
    parameter int HOLD_STEPS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [1:0]        speed,
    input  logic              pwm_wrap,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_upd,
    output logic [2:0]        phase,
    output logic              cycle_done
);

    localparam int                HOLD_W    = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [DUTY_W-1:0] DUTY_MAX  = DUTY_W'(duty_max(DUTY_W));
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

    state_t            state, state_n;
    logic [DUTY_W-1:0] target, target_n;
    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic [DUTY_W-1:0] duty_n;
    logic              upd_n;
    logic              done_n;
    logic              step_tick;

    step_prescaler #(
        .BASE_DIV (BASE_DIV),
        .PRESC_W  (PRESC_W)
    ) u_presc (
        .clk       (clk),
        .rst       (rst),
        .clear     (state == ST_IDLE),
        .speed     (speed),
        .step_tick (step_tick)
    );

    assign phase = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            target     <= '0;
            hold_cnt   <= '0;
            duty       <= '0;
            duty_upd   <= 1'b0;
            cycle_done <= 1'b0;
        end else begin
            state      <= state_n;
            target     <= target_n;
            hold_cnt   <= hold_n;
            duty       <= duty_n;
            duty_upd   <= upd_n;
            cycle_done <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        target_n = target;
        hold_n   = hold_cnt;
        duty_n   = duty;
        upd_n    = 1'b0;
        done_n   = 1'b0;

        if (state == ST_IDLE) begin
            if (en) begin
                state_n  = ST_RAMP_UP;
                target_n = '0;
            end
        end else if (!en) begin
            // Abort drops the LED dark at once rather than waiting for a period boundary.
            state_n  = ST_IDLE;
            target_n = '0;
            duty_n   = '0;
            upd_n    = (duty != '0);
        end else begin
            // Shadow load uses the pre-step target, so a coincident step lands at the next wrap.
            if (pwm_wrap) begin
                duty_n = target;
                upd_n  = (target != duty);
            end
            if (step_tick) begin
                unique case (state)
                    ST_RAMP_UP: begin
                        if (target == DUTY_MAX) begin
                            state_n = ST_HOLD_HI;
                            hold_n  = '0;
                        end else begin
                            target_n = target + DUTY_W'(1);
                        end
                    end
                    ST_HOLD_HI: begin
                        if (hold_cnt == HOLD_LAST) begin
                            state_n = ST_RAMP_DOWN;
                        end else begin
                            hold_n = hold_cnt + HOLD_W'(1);
                        end
                    end
                    ST_RAMP_DOWN: begin
                        if (target == '0) begin
                            state_n = ST_HOLD_LO;
                            hold_n  = '0;
                        end else begin
                            target_n = target - DUTY_W'(1);
                        end
                    end
                    ST_HOLD_LO: begin
                        if (hold_cnt == HOLD_LAST) begin
                            state_n = ST_RAMP_UP;
                            done_n  = 1'b1;
                        end else begin
                            hold_n = hold_cnt + HOLD_W'(1);
                        end
                    end
                    default: state_n = ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_breathe_seq.sv
// tb/tb_breathe_seq.sv - directed vector bench for breathe_seq with small multi-cycle sequences
module tb_breathe_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       pwm_wrap = 1'b0;
    logic [1:0] speed = 2'd0;
    logic [6:0] duty;
    logic       duty_upd;
    logic [2:0] phase;
    logic       cycle_done;

    int total = 0;
    int bad = 0;
    int edge_n = 0;

    typedef struct {
        int         edge_n;
        logic [2:0] phase;
        logic [6:0] duty;
        logic       upd;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    breathe_seq #(
        .DUTY_W     (7),
        .BASE_DIV   (4),
        .PRESC_W    (16),
        .HOLD_STEPS (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .speed      (speed),
        .pwm_wrap   (pwm_wrap),
        .duty       (duty),
        .duty_upd   (duty_upd),
        .phase      (phase),
        .cycle_done (cycle_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic step_to(input int target_edge);
        while (edge_n < target_edge) step();
    endtask

    // Reset, then release with en=1 so edge 1 enters RAMP_UP.
    task automatic start_run(input logic [1:0] spd);
        rst = 1'b0;
        en = 1'b0;
        pwm_wrap = 1'b0;
        speed = spd;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        en = 1'b1;
        pwm_wrap = 1'b1;
        edge_n = 0;
    endtask

    function automatic logic [10:0] outs(input logic [2:0] p, input logic [6:0] d,
                                         input logic u, input logic c);
        return {p, d, u, c};
    endfunction

    initial begin
        int   done_cnt;
        int   exp_duty;
        logic exp_upd;
        int   nd;

        vecs.push_back('{1,    3'd1, 7'd0,   1'b0, 1'b0});
        vecs.push_back('{5,    3'd1, 7'd0,   1'b0, 1'b0});
        vecs.push_back('{6,    3'd1, 7'd1,   1'b1, 1'b0});
        vecs.push_back('{7,    3'd1, 7'd1,   1'b0, 1'b0});
        vecs.push_back('{10,   3'd1, 7'd2,   1'b1, 1'b0});
        vecs.push_back('{510,  3'd1, 7'd127, 1'b1, 1'b0});
        vecs.push_back('{512,  3'd1, 7'd127, 1'b0, 1'b0});
        vecs.push_back('{513,  3'd2, 7'd127, 1'b0, 1'b0});
        vecs.push_back('{521,  3'd3, 7'd127, 1'b0, 1'b0});
        vecs.push_back('{526,  3'd3, 7'd126, 1'b1, 1'b0});
        vecs.push_back('{1030, 3'd3, 7'd0,   1'b1, 1'b0});
        vecs.push_back('{1033, 3'd4, 7'd0,   1'b0, 1'b0});
        vecs.push_back('{1040, 3'd4, 7'd0,   1'b0, 1'b0});
        vecs.push_back('{1041, 3'd1, 7'd0,   1'b0, 1'b1});
        vecs.push_back('{1042, 3'd1, 7'd0,   1'b0, 1'b0});
        vecs.push_back('{1046, 3'd1, 7'd1,   1'b1, 1'b0});

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 32'(outs(phase, duty, duty_upd, cycle_done)), 32'd0);

        // Full breathe cycle against the vector table.
        start_run(2'd0);
        done_cnt = 0;
        foreach (vecs[i]) begin
            while (edge_n < vecs[i].edge_n) begin
                step();
                if (cycle_done) done_cnt++;
            end
            chk($sformatf("vec_e%0d", vecs[i].edge_n),
                32'(outs(phase, duty, duty_upd, cycle_done)),
                32'(outs(vecs[i].phase, vecs[i].duty, vecs[i].upd, vecs[i].done)));
        end
        chk("cycle_done_pulses", 32'(done_cnt), 32'd1);

        // Asynchronous reset in mid ramp.
        start_run(2'd0);
        step_to(165);
        chk("pre_reset_duty", 32'(duty), 32'd40);
        #2;
        rst = 1'b0;
        en = 1'b0;
        #1;
        chk("async_reset", 32'(outs(phase, duty, duty_upd, cycle_done)), 32'd0);
        step();
        rst = 1'b1;
        step();
        chk("post_reset_phase", 32'(phase), 32'd0);

        // Abort at duty 90 with no wrap pending, then re-enable.
        start_run(2'd0);
        step_to(362);
        chk("abort_pre_duty", 32'(duty), 32'd90);
        en = 1'b0;
        pwm_wrap = 1'b0;
        step();
        chk("abort_out", 32'(outs(phase, duty, duty_upd, cycle_done)), 32'(outs(3'd0, 7'd0, 1'b1, 1'b0)));
        en = 1'b1;
        pwm_wrap = 1'b1;
        step();
        chk("restart_out", 32'(outs(phase, duty, duty_upd, cycle_done)), 32'(outs(3'd1, 7'd0, 1'b0, 1'b0)));
        step_to(368);
        chk("restart_e368", 32'(duty), 32'd0);
        step();
        chk("restart_e369", 32'({duty, duty_upd}), 32'({7'd1, 1'b1}));

        // Sparse wraps: every 16 clocks, aligned with a step tick.
        start_run(2'd0);
        pwm_wrap = 1'b0;
        exp_duty = 0;
        for (int e = 1; e <= 60; e++) begin
            pwm_wrap = ((e % 16) == 5);
            step();
            exp_upd = 1'b0;
            if ((e % 16) == 5) begin
                nd = (e - 5) / 4;
                exp_upd = (nd != exp_duty);
                exp_duty = nd;
            end
            chk($sformatf("shadow_e%0d", e), 32'({duty, duty_upd}), 32'({7'(exp_duty), exp_upd}));
        end

        // Slowest speed: 32 clocks per step.
        start_run(2'd3);
        step_to(33);
        chk("speed3_e33", 32'({phase, duty}), 32'({3'd1, 7'd0}));
        step();
        chk("speed3_e34", 32'({duty, duty_upd}), 32'({7'd1, 1'b1}));

        // Speed change mid-count takes effect from the following step.
        start_run(2'd0);
        step_to(2);
        speed = 2'd2;
        step_to(6);
        chk("spdchg_e6", 32'(duty), 32'd1);
        step_to(10);
        chk("spdchg_e10", 32'(duty), 32'd1);
        step_to(21);
        chk("spdchg_e21", 32'(duty), 32'd1);
        step();
        chk("spdchg_e22", 32'(duty), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
